spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//  Output stage of the SNN: consumes the per-timestep output-layer spike words (<8,6>, 0 or 1.0 per lane)
//  produced by the lif neurons, counts spikes per output neuron over NUM_STEPS timesteps, then selects
//  the winning class by sequential argmax. Sits directly downstream of the output-layer lif array; its
//  class result is handed to the AXI/host side via a valid/ready handshake.
// PARAMETERS
//  ACC_BITS   8   width of one spike lane (<ACC_BITS,6> fixed point)
//  NUM_OUT    3   number of output neurons / classes (Iris: 3)
//  NUM_STEPS  25  timesteps per inference; >=1
//  CNT_BITS   5   spike counter width; must satisfy 2**CNT_BITS > NUM_STEPS
//  CLS_BITS   2   class index width; must satisfy 2**CLS_BITS >= NUM_OUT
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst_n      in   1                   asynchronous, active-low reset
//  start      in   1                   pulse: begin a new inference (honoured only in IDLE)
//  busy       out  1                   high in ACCUM, ARGMAX and DONE
//  spk_valid  in   1                   spk_in holds one timestep of spikes
//  spk_ready  out  1                   high only in ACCUM
//  spk_in     in   NUM_OUT*ACC_BITS    lane i = spk_in[i*ACC_BITS +: ACC_BITS], one lif spk_out each
//  cls_valid  out  1                   class result valid (high only in DONE)
//  cls_ready  in   1                   downstream accepts result
//  cls_id     out  CLS_BITS            winning class index
//  cls_count  out  CNT_BITS            spike count of the winning class
// BEHAVIOUR
//  States: IDLE -> ACCUM -> ARGMAX -> DONE -> IDLE.
//  Reset (async, rst_n=0): state=IDLE; all counters, step counter, scan index, best idx/count = 0;
//   busy=0, spk_ready=0, cls_valid=0, cls_id=0, cls_count=0. rst_n low mid-inference aborts immediately.
//  IDLE: start=1 -> clear all NUM_OUT counters and step counter, next state ACCUM. Other inputs ignored.
//  ACCUM: spk_ready=1. Beat accepted when spk_valid&&spk_ready. Per accepted beat: every lane with a
//   nonzero value increments its counter (saturating at 2**CNT_BITS-1); step counter increments.
//   Zero lanes leave counters unchanged. No beat -> no state change (stalls are unlimited).
//   Beat accepted while step==NUM_STEPS-1 -> counts include that beat, next state ARGMAX.
//  ARGMAX: scans lane i=0..NUM_OUT-1, one lane per cycle. i=0 loads best={0,cnt0}; i>0 replaces best
//   only if cnt_i > best_count (strict: ties resolve to lowest index). After lane NUM_OUT-1 -> DONE.
//  DONE: cls_valid=1, cls_id/cls_count stable while cls_valid=1. cls_valid&&cls_ready -> IDLE next cycle.
//  Latency: last beat accepted at cycle t -> ARGMAX cycles t+1..t+NUM_OUT -> cls_valid first high at
//   t+NUM_OUT+1. Min inference = 1 (start) + NUM_STEPS + NUM_OUT cycles to cls_valid.
//  start while busy is ignored (no restart, no counter clear). start in the same cycle the DONE
//   handshake completes is ignored; a new start must arrive in IDLE.
//  cls_id/cls_count hold last result after handshake until next ARGMAX overwrites them.
//  spk_in is not sampled outside ACCUM; spk_valid with spk_ready=0 has no effect.
//  All-zero counts -> cls_id=0, cls_count=0 (valid result, not an error).
// TESTING
//  T1 reset: rst_n=0 with random inputs -> all outputs 0, state IDLE; release, no start -> nothing moves.
//  T2 basic: start, 25 beats with lane1=0x40 every beat, lanes 0/2=0 -> cls_id=1, cls_count=25,
//     cls_valid exactly 4 cycles after last accepted beat.
//  T3 tie: lane0 spikes 10 beats, lane2 spikes 10 beats, lane1 5 -> cls_id=0, cls_count=10.
//  T4 stalls/backpressure: random spk_valid gaps (25 beats over ~60 cycles), hold cls_ready=0 for
//     7 cycles -> counts unaffected by gaps, cls_id/cls_count stable 7 cycles, IDLE after handshake.
//  T5 ignored start: pulse start during ACCUM (beat 12) and in DONE -> no counter clear, result
//     identical to same stimulus without the extra pulses.
//  T6 reset mid-run: rst_n=0 at beat 13, release, start new run with lane2 only -> cls_id=2, count=25,
//     no residue from aborted run.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: output stage of the SNN.
// Counts output-layer spikes per neuron over NUM_STEPS timesteps, then picks
// the winning class with a sequential argmax (ties go to the lowest index).
// The result is offered downstream through a valid/ready handshake.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a new inference (honoured only when idle)
//   busy       high while accumulating, scanning or holding a result
//   spk_valid  spk_in carries one timestep of spikes
//   spk_ready  high only while accumulating
//   spk_in     NUM_OUT lanes of ACC_BITS, lane i = spk_in[i*ACC_BITS +: ACC_BITS]
//   cls_valid  class result valid
//   cls_ready  downstream accepts the result
//   cls_id     winning class index
//   cls_count  spike count of the winning class
module spike_rate_decoder #(
    parameter int unsigned ACC_BITS  = 8,
    parameter int unsigned NUM_OUT   = 3,
    parameter int unsigned NUM_STEPS = 25,
    parameter int unsigned CNT_BITS  = 5,
    parameter int unsigned CLS_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    input  logic                        spk_valid,
    output logic                        spk_ready,
    input  logic [NUM_OUT*ACC_BITS-1:0] spk_in,
    output logic                        cls_valid,
    input  logic                        cls_ready,
    output logic [CLS_BITS-1:0]         cls_id,
    output logic [CNT_BITS-1:0]         cls_count
);

    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(NUM_STEPS - 1);
    localparam logic [CLS_BITS-1:0] LAST_IDX  = CLS_BITS'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ARGMAX,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [CNT_BITS-1:0] cnt_q [NUM_OUT];
    logic [CNT_BITS-1:0] cnt_d [NUM_OUT];
    logic [CNT_BITS-1:0] step_q;
    logic [CLS_BITS-1:0] scan_q;
    logic [CLS_BITS-1:0] best_idx_q;
    logic [CNT_BITS-1:0] best_cnt_q;
    logic                busy_q;
    logic                spk_ready_q;
    logic                cls_valid_q;

    // Saturating per-lane increment for the current beat; used only on accept.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((spk_in[i*ACC_BITS +: ACC_BITS] != '0) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
        end
    end

    // Control FSM with datapath; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt_q[i] <= '0;
            end
            step_q      <= '0;
            scan_q      <= '0;
            best_idx_q  <= '0;
            best_cnt_q  <= '0;
            busy_q      <= 1'b0;
            spk_ready_q <= 1'b0;
            cls_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            cnt_q[i] <= '0;
                        end
                        step_q      <= '0;
                        busy_q      <= 1'b1;
                        spk_ready_q <= 1'b1;
                        state_q     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (spk_valid && spk_ready_q) begin
                        cnt_q  <= cnt_d;
                        step_q <= step_q + CNT_BITS'(1);
                        if (step_q == LAST_STEP) begin
                            spk_ready_q <= 1'b0;
                            scan_q      <= '0;
                            state_q     <= S_ARGMAX;
                        end
                    end
                end
                S_ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((scan_q == '0) || (cnt_q[scan_q] > best_cnt_q)) begin
                        best_idx_q <= scan_q;
                        best_cnt_q <= cnt_q[scan_q];
                    end
                    if (scan_q == LAST_IDX) begin
                        cls_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        scan_q <= scan_q + CLS_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (cls_ready) begin
                        cls_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign spk_ready = spk_ready_q;
    assign cls_valid = cls_valid_q;
    assign cls_id    = best_idx_q;
    assign cls_count = best_cnt_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: randomized self-checking bench for spike_rate_decoder.
// Expected class/count come from a counting model over the stored beat list.
module tb_spike_rate_decoder;

    localparam int unsigned ACC_BITS  = 8;
    localparam int unsigned NUM_OUT   = 3;
    localparam int unsigned NUM_STEPS = 25;
    localparam int unsigned CNT_BITS  = 5;
    localparam int unsigned CLS_BITS  = 2;
    localparam int unsigned SPK_W     = NUM_OUT * ACC_BITS;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                start     = 1'b0;
    logic                spk_valid = 1'b0;
    logic                cls_ready = 1'b0;
    logic [SPK_W-1:0]    spk_in    = '0;
    logic                busy;
    logic                spk_ready;
    logic                cls_valid;
    logic [CLS_BITS-1:0] cls_id;
    logic [CNT_BITS-1:0] cls_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [SPK_W-1:0] beats [NUM_STEPS];

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .ACC_BITS (ACC_BITS),
        .NUM_OUT  (NUM_OUT),
        .NUM_STEPS(NUM_STEPS),
        .CNT_BITS (CNT_BITS),
        .CLS_BITS (CLS_BITS)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .spk_valid(spk_valid),
        .spk_ready(spk_ready),
        .spk_in   (spk_in),
        .cls_valid(cls_valid),
        .cls_ready(cls_ready),
        .cls_id   (cls_id),
        .cls_count(cls_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Spike counts per lane from the beat list, then the first lane holding the maximum.
    function automatic void model(output int id, output int cnt);
        int counts [NUM_OUT];
        int mx;
        mx = 0;
        for (int i = 0; i < NUM_OUT; i++) begin
            counts[i] = 0;
            for (int b = 0; b < NUM_STEPS; b++) begin
                if (beats[b][i*ACC_BITS +: ACC_BITS] != '0) counts[i]++;
            end
            if (counts[i] > (2**CNT_BITS) - 1) counts[i] = (2**CNT_BITS) - 1;
            if (counts[i] > mx) mx = counts[i];
        end
        id = -1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (id < 0 && counts[i] == mx) id = i;
        end
        cnt = mx;
    endfunction

    function automatic logic [ACC_BITS-1:0] rand_lane();
        if ($urandom_range(1, 0) == 0) return '0;
        return ACC_BITS'($urandom_range(255, 1));
    endfunction

    // Build beats where lane i spikes in the first n[i] timesteps.
    task automatic fill_counts(input int n0, input int n1, input int n2);
        int n [NUM_OUT];
        n[0] = n0; n[1] = n1; n[2] = n2;
        for (int b = 0; b < NUM_STEPS; b++) begin
            beats[b] = '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (b < n[i]) beats[b][i*ACC_BITS +: ACC_BITS] = ACC_BITS'(8'h40);
            end
        end
    endtask

    task automatic fill_random;
        for (int b = 0; b < NUM_STEPS; b++) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                beats[b][i*ACC_BITS +: ACC_BITS] = rand_lane();
            end
        end
    endtask

    // One full inference from IDLE through the result handshake.
    task automatic run_inf(input string tag, input int max_gap, input int hold, input bit extra_start);
        int lat;
        int e_id;
        int e_cnt;
        model(e_id, e_cnt);
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq({tag, ".busy_acc"}, 32'(busy), 32'd1);
        for (int b = 0; b < NUM_STEPS; b++) begin
            int gap;
            gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gap; g++) begin
                spk_valid = 1'b0;
                spk_in    = SPK_W'($urandom);
                tick;
            end
            check_eq({tag, ".spk_ready"}, 32'(spk_ready), 32'd1);
            spk_valid = 1'b1;
            spk_in    = beats[b];
            start     = extra_start && (b == 12);
            tick;
            start     = 1'b0;
            spk_valid = 1'b0;
        end
        // Garbage beats offered while scanning must be ignored.
        lat = 1;
        while (cls_valid !== 1'b1 && lat < 20) begin
            spk_valid = 1'b1;
            spk_in    = SPK_W'($urandom);
            tick;
            lat++;
        end
        spk_valid = 1'b0;
        check_eq({tag, ".latency"}, 32'(lat), 32'(NUM_OUT + 1));
        check_eq({tag, ".cls_id"}, 32'(cls_id), 32'(e_id));
        check_eq({tag, ".cls_count"}, 32'(cls_count), 32'(e_cnt));
        cls_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = extra_start && (h == 0);
            tick;
            start = 1'b0;
            check_eq({tag, ".hold_valid"}, 32'(cls_valid), 32'd1);
            check_eq({tag, ".hold_id"}, 32'(cls_id), 32'(e_id));
            check_eq({tag, ".hold_count"}, 32'(cls_count), 32'(e_cnt));
        end
        cls_ready = 1'b1;
        start     = extra_start;
        tick;
        cls_ready = 1'b0;
        start     = 1'b0;
        check_eq({tag, ".valid_after"}, 32'(cls_valid), 32'd0);
        check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, ".id_held"}, 32'(cls_id), 32'(e_id));
        tick;
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".idle_ready"}, 32'(spk_ready), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".spk_ready"}, 32'(spk_ready), 32'd0);
        check_eq({tag, ".cls_valid"}, 32'(cls_valid), 32'd0);
        check_eq({tag, ".cls_id"}, 32'(cls_id), 32'd0);
        check_eq({tag, ".cls_count"}, 32'(cls_count), 32'd0);
    endtask

    initial begin
        // T1: reset with random inputs, then idle without start
        for (int k = 0; k < 4; k++) begin
            start     = 1'($urandom);
            spk_valid = 1'($urandom);
            cls_ready = 1'($urandom);
            spk_in    = SPK_W'($urandom);
            tick;
            check_all_zero("t1_reset");
        end
        start = 1'b0; spk_valid = 1'b0; cls_ready = 1'b0; spk_in = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            spk_valid = 1'($urandom);
            spk_in    = SPK_W'($urandom);
            tick;
        end
        spk_valid = 1'b0;
        check_all_zero("t1_idle");

        // T2: lane1 spikes every beat
        fill_counts(0, 25, 0);
        run_inf("t2_basic", 0, 0, 1'b0);

        // T3: tie between lanes 0 and 2
        fill_counts(10, 5, 10);
        run_inf("t3_tie", 0, 0, 1'b0);

        // T4: random gaps and held-off result
        fill_random();
        run_inf("t4_stall", 4, 7, 1'b0);

        // T5: extra start pulses in ACCUM, DONE and at handshake
        fill_random();
        run_inf("t5_start", 2, 3, 1'b1);

        // All-zero spikes still give a valid class 0 result
        fill_counts(0, 0, 0);
        run_inf("zero", 1, 1, 1'b0);

        // T6: reset at beat 13, then a clean lane2-only run
        fill_counts(25, 0, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int b = 0; b < 13; b++) begin
            spk_valid = 1'b1;
            spk_in    = beats[b];
            tick;
        end
        spk_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_abort");
        tick;
        rst_n = 1'b1;
        tick;
        check_all_zero("t6_release");
        fill_counts(0, 0, 25);
        run_inf("t6_rerun", 0, 0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_inf("rand", int'($urandom_range(3, 0)), int'($urandom_range(5, 0)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
